// File: rtl/median_line_sequencer.sv
`timescale 1ns/1ps
// Frame sequencer for the 4-entry rotating line-buffer bank feeding the 3x3
// median filter. Steers incoming lines to buffers, launches 3-line read bursts
// once enough lines are stored, and reports per-line and end-of-frame events.
module median_line_sequencer #(
    parameter int COLS = 512,
    parameter int ROWS = 512
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_pix_valid,
    output logic       o_pix_ready,
    output logic [3:0] o_wr_sel,
    output logic       o_wr_en,
    output logic       o_rd_en,
    output logic [3:0] o_rd_mask,
    output logic [1:0] o_rd_base,
    output logic [9:0] o_rd_col,
    output logic [9:0] o_out_row,
    output logic       o_line_done,
    output logic       o_frame_done,
    output logic       o_busy
);

    localparam logic [9:0] COL_LAST = 10'(COLS - 1);
    localparam logic [9:0] ROW_END  = 10'(ROWS);
    localparam logic [9:0] OUT_ROWS = 10'(ROWS - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [9:0] wr_col_reg;
    logic [9:0] wr_row_reg;
    logic [2:0] lines_stored_reg;
    logic [3:0] wr_sel_reg;
    logic [1:0] rd_base_reg;
    logic       rd_en_reg;
    logic [9:0] rd_col_reg;
    logic [9:0] out_row_reg;
    logic       line_done_reg;

    logic start_frame;
    logic pix_ready;
    logic wr_en;
    logic wr_line_end;
    logic rd_burst_end;
    logic rd_launch;

    // Handshake and event decode shared by the FSM and the datapath
    always_comb begin
        start_frame  = (state_reg == S_IDLE) && i_start;
        pix_ready    = ((state_reg == S_FILL) || (state_reg == S_RUN)) &&
                       (lines_stored_reg < 3'd4) && (wr_row_reg < ROW_END);
        wr_en        = i_pix_valid && pix_ready;
        wr_line_end  = wr_en && (wr_col_reg == COL_LAST);
        rd_burst_end = rd_en_reg && (rd_col_reg == COL_LAST);
        // line_done_reg blocks a relaunch on the cycle straight after a burst
        rd_launch    = (state_reg == S_RUN) && !rd_en_reg && !line_done_reg &&
                       (lines_stored_reg >= 3'd3) && (out_row_reg < OUT_ROWS);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: FILL waits for three stored lines, RUN ends after the last output row
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (i_start) state_next = S_FILL;
            S_FILL: if (lines_stored_reg >= 3'd3) state_next = S_RUN;
            S_RUN:  if (line_done_reg && (out_row_reg == OUT_ROWS)) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Write path: column/row counters and one-hot buffer rotation
    always_ff @(posedge i_clk) begin
        if (i_rst || start_frame) begin
            wr_col_reg <= '0;
            wr_row_reg <= '0;
            wr_sel_reg <= 4'b0001;
        end else if (wr_en) begin
            if (wr_col_reg == COL_LAST) begin
                wr_col_reg <= '0;
                wr_row_reg <= wr_row_reg + 10'd1;
                wr_sel_reg <= {wr_sel_reg[2:0], wr_sel_reg[3]};
            end else begin
                wr_col_reg <= wr_col_reg + 10'd1;
            end
        end
    end

    // Read path: burst launch, column sweep and window advance at burst end
    always_ff @(posedge i_clk) begin
        if (i_rst || start_frame) begin
            rd_en_reg     <= 1'b0;
            rd_col_reg    <= '0;
            rd_base_reg   <= '0;
            out_row_reg   <= '0;
            line_done_reg <= 1'b0;
        end else begin
            line_done_reg <= 1'b0;
            if (rd_burst_end) begin
                rd_en_reg     <= 1'b0;
                rd_col_reg    <= '0;
                line_done_reg <= 1'b1;
                rd_base_reg   <= rd_base_reg + 2'd1;
                out_row_reg   <= out_row_reg + 10'd1;
            end else if (rd_en_reg) begin
                rd_col_reg <= rd_col_reg + 10'd1;
            end else if (rd_launch) begin
                rd_en_reg <= 1'b1;
            end
        end
    end

    // Occupancy: a finished write line adds one, a finished burst frees the oldest
    always_ff @(posedge i_clk) begin
        if (i_rst || start_frame || (state_reg == S_DONE)) begin
            lines_stored_reg <= '0;
        end else begin
            case ({wr_line_end, rd_burst_end})
                2'b10:   lines_stored_reg <= lines_stored_reg + 3'd1;
                2'b01:   lines_stored_reg <= lines_stored_reg - 3'd1;
                default: lines_stored_reg <= lines_stored_reg;
            endcase
        end
    end

    // Read mask: the three buffers starting at rd_base (wrapping) follow rd_en
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_mask
        localparam logic [1:0] IDX = 2'(gi);
        logic [1:0] offset;
        assign offset        = IDX - rd_base_reg;
        assign o_rd_mask[gi] = rd_en_reg && (offset != 2'd3);
    end

    assign o_pix_ready  = pix_ready;
    assign o_wr_en      = wr_en;
    assign o_wr_sel     = wr_sel_reg;
    assign o_rd_en      = rd_en_reg;
    assign o_rd_base    = rd_base_reg;
    assign o_rd_col     = rd_col_reg;
    assign o_out_row    = out_row_reg;
    assign o_line_done  = line_done_reg;
    assign o_frame_done = (state_reg == S_DONE);
    assign o_busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_median_line_sequencer.sv
`timescale 1ns/1ps
// Directed bench for median_line_sequencer: one 8x6 instance for fill, full
// frame, simultaneous-end and reset cases, one 8x12 instance for backpressure.
module tb_median_line_sequencer;

    localparam int NREC = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: COLS=8, ROWS=6
    logic       a_start, a_valid;
    logic       a_ready, a_wr_en, a_rd_en, a_line_done, a_frame_done, a_busy;
    logic [3:0] a_wr_sel, a_rd_mask;
    logic [1:0] a_rd_base;
    logic [9:0] a_rd_col, a_out_row;

    // Instance B: COLS=8, ROWS=12
    logic       b_start, b_valid;
    logic       b_ready, b_wr_en, b_rd_en, b_line_done, b_frame_done, b_busy;
    logic [3:0] b_wr_sel, b_rd_mask;
    logic [1:0] b_rd_base;
    logic [9:0] b_rd_col, b_out_row;

    median_line_sequencer #(.COLS(8), .ROWS(6)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_pix_valid(a_valid),
        .o_pix_ready(a_ready), .o_wr_sel(a_wr_sel), .o_wr_en(a_wr_en),
        .o_rd_en(a_rd_en), .o_rd_mask(a_rd_mask), .o_rd_base(a_rd_base),
        .o_rd_col(a_rd_col), .o_out_row(a_out_row), .o_line_done(a_line_done),
        .o_frame_done(a_frame_done), .o_busy(a_busy)
    );

    median_line_sequencer #(.COLS(8), .ROWS(12)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_pix_valid(b_valid),
        .o_pix_ready(b_ready), .o_wr_sel(b_wr_sel), .o_wr_en(b_wr_en),
        .o_rd_en(b_rd_en), .o_rd_mask(b_rd_mask), .o_rd_base(b_rd_base),
        .o_rd_col(b_rd_col), .o_out_row(b_out_row), .o_line_done(b_line_done),
        .o_frame_done(b_frame_done), .o_busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle trace of instance A, cycle 0 = first cycle after start is taken
    logic [3:0] r_wr_sel [NREC];
    logic [3:0] r_mask   [NREC];
    logic [1:0] r_base   [NREC];
    logic [9:0] r_col    [NREC];
    logic [9:0] r_row    [NREC];
    logic       r_ready  [NREC];
    logic       r_wr_en  [NREC];
    logic       r_rd_en  [NREC];
    logic       r_ld     [NREC];
    logic       r_fd     [NREC];
    logic       r_busy   [NREC];
    int acc_a, ld_a, fd_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arm instance A; returns in cycle 0 of the new frame
    task automatic start_a();
        a_start = 1'b1;
        a_valid = 1'b0;
        tick();
        a_start = 1'b0;
    endtask

    // Run instance A for NREC cycles, valid high except at gap cycles, start pulsed at start_at
    task automatic record_a(input int gap0, input int gap1, input int start_at);
        acc_a = 0; ld_a = 0; fd_a = 0;
        for (int t = 0; t < NREC; t++) begin
            a_valid = !((t == gap0) || (t == gap1));
            a_start = (t == start_at);
            #1;
            r_wr_sel[t] = a_wr_sel;  r_mask[t]  = a_rd_mask; r_base[t] = a_rd_base;
            r_col[t]    = a_rd_col;  r_row[t]   = a_out_row; r_ready[t] = a_ready;
            r_wr_en[t]  = a_wr_en;   r_rd_en[t] = a_rd_en;   r_ld[t]    = a_line_done;
            r_fd[t]     = a_frame_done; r_busy[t] = a_busy;
            acc_a += int'(a_wr_en);
            ld_a  += int'(a_line_done);
            fd_a  += int'(a_frame_done);
            tick();
        end
        a_valid = 1'b0;
        a_start = 1'b0;
    endtask

    // Expected trace of an 8x6 frame with continuous valid
    task automatic check_frame6(input string p);
        chk({p, "_wr_sel_c7"},  32'(r_wr_sel[7]),  32'h1);
        chk({p, "_wr_sel_c8"},  32'(r_wr_sel[8]),  32'h2);
        chk({p, "_wr_sel_c16"}, 32'(r_wr_sel[16]), 32'h4);
        chk({p, "_wr_sel_c24"}, 32'(r_wr_sel[24]), 32'h8);
        chk({p, "_wr_sel_c32"}, 32'(r_wr_sel[32]), 32'h1);
        chk({p, "_rd_en_c25"},  32'(r_rd_en[25]),  32'h0);
        chk({p, "_rd_en_c26"},  32'(r_rd_en[26]),  32'h1);
        chk({p, "_mask_c26"},   32'(r_mask[26]),   32'h7);
        chk({p, "_rd_col_c33"}, 32'(r_col[33]),    32'd7);
        chk({p, "_ready_c32"},  32'(r_ready[32]),  32'h0);
        chk({p, "_ld_c34"},     32'(r_ld[34]),     32'h1);
        chk({p, "_ready_c34"},  32'(r_ready[34]),  32'h1);
        chk({p, "_rd_en_c35"},  32'(r_rd_en[35]),  32'h0);
        chk({p, "_rd_en_c36"},  32'(r_rd_en[36]),  32'h1);
        chk({p, "_base_c36"},   32'(r_base[36]),   32'h1);
        chk({p, "_mask_c36"},   32'(r_mask[36]),   32'hE);
        chk({p, "_mask_c46"},   32'(r_mask[46]),   32'hD);
        chk({p, "_mask_c56"},   32'(r_mask[56]),   32'hB);
        chk({p, "_ld_c64"},     32'(r_ld[64]),     32'h1);
        chk({p, "_fd_c64"},     32'(r_fd[64]),     32'h0);
        chk({p, "_fd_c65"},     32'(r_fd[65]),     32'h1);
        chk({p, "_out_row_c65"},32'(r_row[65]),    32'd4);
        chk({p, "_busy_c65"},   32'(r_busy[65]),   32'h1);
        chk({p, "_busy_c66"},   32'(r_busy[66]),   32'h0);
        chk({p, "_ready_c66"},  32'(r_ready[66]),  32'h0);
        chk({p, "_accepted"},   32'(acc_a),        32'd48);
        chk({p, "_line_dones"}, 32'(ld_a),         32'd4);
        chk({p, "_frame_dones"},32'(fd_a),         32'd1);
    endtask

    initial begin
        int acc_b, ld_b, fd_b, bad_wren, ld_no_ready, stalls;
        bit b_done;

        // 1. Reset with start held high
        rst = 1'b1;
        a_start = 1'b1; a_valid = 1'b0;
        b_start = 1'b1; b_valid = 1'b0;
        tick();
        tick();
        chk("rst_wr_sel",     32'(a_wr_sel),     32'h1);
        chk("rst_rd_base",    32'(a_rd_base),    32'h0);
        chk("rst_ready",      32'(a_ready),      32'h0);
        chk("rst_rd_en",      32'(a_rd_en),      32'h0);
        chk("rst_line_done",  32'(a_line_done),  32'h0);
        chk("rst_frame_done", 32'(a_frame_done), 32'h0);
        chk("rst_busy",       32'(a_busy),       32'h0);
        chk("rst_busy_b",     32'(b_busy),       32'h0);
        a_start = 1'b0; b_start = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_busy",  32'(a_busy),       32'h0);

        // 2/3. Fill and full 8x6 frame with continuous valid
        start_a();
        chk("start_busy",  32'(a_busy),  32'h1);
        record_a(-1, -1, -1);
        check_frame6("frame");

        // 5. Write-line end coincides with burst end; start pulsed in RUN is ignored
        start_a();
        record_a(26, 27, 30);
        chk("sim_wr_en_c33",  32'(r_wr_en[33]), 32'h1);
        chk("sim_rd_col_c33", 32'(r_col[33]),   32'd7);
        chk("sim_ready_c32",  32'(r_ready[32]), 32'h1);
        chk("sim_ld_c34",     32'(r_ld[34]),    32'h1);
        chk("sim_ready_c34",  32'(r_ready[34]), 32'h1);
        chk("sim_rd_en_c35",  32'(r_rd_en[35]), 32'h0);
        chk("sim_rd_en_c36",  32'(r_rd_en[36]), 32'h1);
        chk("sim_mask_c36",   32'(r_mask[36]),  32'hE);
        chk("sim_accepted",   32'(acc_a),       32'd48);
        chk("sim_line_dones", 32'(ld_a),        32'd4);
        chk("sim_frame_dones",32'(fd_a),        32'd1);

        // 6. Mid-frame reset after 20 pixels, then replay of the full frame
        start_a();
        a_valid = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        chk("mid_wr_sel_before", 32'(a_wr_sel), 32'h4);
        a_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_wr_sel",  32'(a_wr_sel),    32'h1);
        chk("mid_rst_busy",    32'(a_busy),      32'h0);
        chk("mid_rst_ready",   32'(a_ready),     32'h0);
        chk("mid_rst_rd_en",   32'(a_rd_en),     32'h0);
        chk("mid_rst_rd_col",  32'(a_rd_col),    32'h0);
        chk("mid_rst_out_row", 32'(a_out_row),   32'h0);
        chk("mid_rst_rd_base", 32'(a_rd_base),   32'h0);
        rst = 1'b0;
        tick();
        start_a();
        record_a(-1, -1, -1);
        check_frame6("replay");

        // 4. Backpressure on the 8x12 instance
        acc_b = 0; ld_b = 0; fd_b = 0; bad_wren = 0; ld_no_ready = 0; stalls = 0;
        b_done = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        for (int t = 0; t < 400 && !b_done; t++) begin
            #1;
            if (b_wr_en && !b_ready) bad_wren++;
            if (b_line_done && (acc_b < 96) && !b_ready) ld_no_ready++;
            if (b_busy && !b_ready && (acc_b < 96)) stalls++;
            acc_b += int'(b_wr_en);
            ld_b  += int'(b_line_done);
            fd_b  += int'(b_frame_done);
            if (b_frame_done) b_done = 1'b1;
            tick();
        end
        b_valid = 1'b0;
        chk("bp_frame_done_seen", 32'(b_done),      32'h1);
        chk("bp_accepted",        32'(acc_b),       32'd96);
        chk("bp_line_dones",      32'(ld_b),        32'd10);
        chk("bp_frame_dones",     32'(fd_b),        32'd1);
        chk("bp_wr_en_gated",     32'(bad_wren),    32'd0);
        chk("bp_ready_after_ld",  32'(ld_no_ready), 32'd0);
        chk("bp_stalled",         32'(stalls > 0),  32'h1);
        chk("bp_rd_base_end",     32'(b_rd_base),   32'h2);
        chk("bp_out_row_end",     32'(b_out_row),   32'd10);
        chk("bp_busy_end",        32'(b_busy),      32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
